// File: rtl/keypoint_collector.sv
// Turns the dense NMS pixel stream into a sparse keypoint list with raster coordinates,
// buffered in a small FIFO and drained over valid/ready. Tracks per-frame count, drops and done.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  S_IDLE    | no frame in progress; i_valid ignored
//  S_SKIP    | discarding upstream pipeline-fill beats before pixel (0,0)
//  S_COLLECT | each i_valid beat is one raster pixel; flagged pixels pushed
//  S_DRAIN   | frame scanned; waiting for the consumer to empty the FIFO
//  S_DONE    | o_frame_done high for this one cycle
module keypoint_collector #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int PIX_DELAY  = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_KP     = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_start,
    input  logic        i_valid,
    input  logic        i_flag,
    input  logic [7:0]  i_score,
    input  logic [15:0] i_depth,
    output logic        o_kp_valid,
    input  logic        i_kp_ready,
    output logic [9:0]  o_kp_x,
    output logic [8:0]  o_kp_y,
    output logic [7:0]  o_kp_score,
    output logic [15:0] o_kp_depth,
    output logic [9:0]  o_kp_count,
    output logic [9:0]  o_drop_cnt,
    output logic        o_frame_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (PIX_DELAY > 1) ? $clog2(PIX_DELAY + 1) : 1;
    localparam int EW = 10 + 9 + 8 + 16;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_SKIP, S_COLLECT, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] skip_q, skip_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [9:0]    kp_count_q, kp_count_d;
    logic [9:0]    drop_cnt_q, drop_cnt_d;
    logic          frame_done_q, frame_done_d;

    logic empty, full, pop, push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && i_kp_ready;

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        x_d          = x_q;
        y_d          = y_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        mem_d        = mem_q;
        kp_count_d   = kp_count_q;
        drop_cnt_d   = drop_cnt_q;
        frame_done_d = 1'b0;
        push         = 1'b0;

        if (i_frame_start) begin
            state_d    = (PIX_DELAY > 0) ? S_SKIP : S_COLLECT;
            skip_d     = SW'(PIX_DELAY);
            x_d        = '0;
            y_d        = '0;
            wr_d       = '0;
            rd_d       = '0;
            kp_count_d = '0;
            drop_cnt_d = '0;
        end else begin
            if (pop) begin
                rd_d = rd_q + PTR_ONE;
            end
            unique case (state_q)
                S_SKIP: begin
                    if (i_valid) begin
                        if (skip_q <= SW'(1)) begin
                            state_d = S_COLLECT;
                        end else begin
                            skip_d = skip_q - SW'(1);
                        end
                    end
                end
                S_COLLECT: begin
                    if (i_valid) begin
                        if (i_flag) begin
                            // A pop in the same cycle frees the slot this push needs.
                            if ((kp_count_q < 10'(MAX_KP)) && (!full || pop)) begin
                                push = 1'b1;
                            end else if (drop_cnt_q != 10'h3ff) begin
                                drop_cnt_d = drop_cnt_q + 10'd1;
                            end
                        end
                        if (x_q == 10'(WIDTH - 1)) begin
                            x_d = '0;
                            if (y_q == 9'(HEIGHT - 1)) begin
                                state_d = S_DRAIN;
                            end else begin
                                y_d = y_q + 9'd1;
                            end
                        end else begin
                            x_d = x_q + 10'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (empty) begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            if (push) begin
                mem_d[wr_q[AW-1:0]] = {x_q, y_q, i_score, i_depth};
                wr_d                = wr_q + PTR_ONE;
                kp_count_d          = kp_count_q + 10'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            skip_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            kp_count_q   <= '0;
            drop_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            x_q          <= x_d;
            y_q          <= y_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            kp_count_q   <= kp_count_d;
            drop_cnt_q   <= drop_cnt_d;
            frame_done_q <= frame_done_d;
            mem_q        <= mem_d;
        end
    end

    assign o_kp_valid = !empty;
    assign {o_kp_x, o_kp_y, o_kp_score, o_kp_depth} = mem_q[rd_q[AW-1:0]];
    assign o_kp_count   = kp_count_q;
    assign o_drop_cnt   = drop_cnt_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_keypoint_collector.sv
// Three collectors (plain, PIX_DELAY=11, MAX_KP=3) share one stimulus stream; each is compared
// every cycle against a frame-level reference model built on pixel indices and queues.
module tb_keypoint_collector;

    localparam int W     = 640;
    localparam int H     = 4;
    localparam int NI    = 3;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fs = 1'b0, vld = 1'b0, flag = 1'b0, rdy = 1'b0;
    logic [7:0]  score = '0;
    logic [15:0] depth = '0;

    logic        kpv [NI];
    logic [9:0]  kx  [NI];
    logic [8:0]  ky  [NI];
    logic [7:0]  ks  [NI];
    logic [15:0] kd  [NI];
    logic [9:0]  kc  [NI];
    logic [9:0]  dc  [NI];
    logic        fd  [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        keypoint_collector #(
            .WIDTH(W), .HEIGHT(H), .PIX_DELAY(gi == 1 ? 11 : 0),
            .FIFO_DEPTH(DEPTH), .MAX_KP(gi == 2 ? 3 : 1023)
        ) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs), .i_valid(vld),
            .i_flag(flag), .i_score(score), .i_depth(depth),
            .o_kp_valid(kpv[gi]), .i_kp_ready(rdy),
            .o_kp_x(kx[gi]), .o_kp_y(ky[gi]), .o_kp_score(ks[gi]), .o_kp_depth(kd[gi]),
            .o_kp_count(kc[gi]), .o_drop_cnt(dc[gi]), .o_frame_done(fd[gi])
        );
    end

    // Reference model state per instance
    logic [42:0] mq [NI][$];
    int  beat_idx  [NI];
    bit  active    [NI];
    bit  pending   [NI];
    int  m_cnt     [NI];
    int  m_drop    [NI];
    bit  done_exp  [NI];
    bit  done_seen [NI];

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pd_of(input int i);
        return (i == 1) ? 11 : 0;
    endfunction

    function automatic int mk_of(input int i);
        return (i == 2) ? 3 : 1023;
    endfunction

    task automatic model_step(input int i);
        bit pop, push;
        int p;
        pop  = (mq[i].size() > 0) && rdy;
        push = 1'b0;
        p    = 0;
        done_exp[i] = 1'b0;
        if (fs) begin
            mq[i].delete();
            m_cnt[i]    = 0;
            m_drop[i]   = 0;
            beat_idx[i] = 0;
            active[i]   = 1'b1;
            pending[i]  = 1'b0;
        end else begin
            if (pending[i] && mq[i].size() == 0) begin
                done_exp[i] = 1'b1;
                pending[i]  = 1'b0;
            end
            if (active[i] && vld) begin
                if (beat_idx[i] < pd_of(i)) begin
                    beat_idx[i]++;
                end else begin
                    p = beat_idx[i] - pd_of(i);
                    beat_idx[i]++;
                    if (flag) begin
                        if (m_cnt[i] < mk_of(i) && (mq[i].size() < DEPTH || pop)) push = 1'b1;
                        else if (m_drop[i] < 1023) m_drop[i]++;
                    end
                    if (p == W * H - 1) begin
                        active[i]  = 1'b0;
                        pending[i] = 1'b1;
                    end
                end
            end
            if (pop) void'(mq[i].pop_front());
            if (push) begin
                mq[i].push_back({10'(p % W), 9'(p / W), score, depth});
                m_cnt[i]++;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("valid%0d", i), 64'(kpv[i]), 64'(mq[i].size() > 0));
            if (mq[i].size() > 0)
                check_val($sformatf("head%0d", i), 64'({kx[i], ky[i], ks[i], kd[i]}), 64'(mq[i][0]));
            check_val($sformatf("count%0d", i), 64'(kc[i]), 64'(m_cnt[i]));
            check_val($sformatf("drop%0d", i), 64'(dc[i]), 64'(m_drop[i]));
            check_val($sformatf("done%0d", i), 64'(fd[i]), 64'(done_exp[i]));
            if (fd[i]) done_seen[i] = 1'b1;
        end
    endtask

    task automatic cycle(input bit f, input bit v, input bit fl, input bit r);
        @(negedge clk);
        fs = f; vld = v; flag = fl; rdy = r;
        score = 8'($urandom);
        depth = 16'($urandom);
        if (f) for (int i = 0; i < NI; i++) done_seen[i] = 1'b0;
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_step(i);
        #1 check_outputs();
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    endtask

    int saved, extra;

    initial begin
        for (int i = 0; i < NI; i++) begin
            beat_idx[i] = 0; active[i] = 0; pending[i] = 0;
            m_cnt[i] = 0; m_drop[i] = 0; done_exp[i] = 0; done_seen[i] = 0;
        end

        repeat (3) @(negedge clk);
        check_val("rst_x", 64'(kx[0]), 64'd0);
        check_val("rst_depth", 64'(kd[0]), 64'd0);
        check_outputs();
        rst_n = 1'b1;

        // Idle beats before any frame are ignored
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b1, 1'b1);

        // T1: one keypoint at beat 645, then frame completion
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        for (int b = 0; b < W * H; b++) begin
            cycle(1'b0, 1'b1, b == 645, 1'b1);
            if (b == 645) begin
                check_val("t1_valid", 64'(kpv[0]), 64'd1);
                check_val("t1_xy", 64'({kx[0], ky[0]}), 64'({10'd5, 9'd1}));
            end
        end
        extra = 0;
        while (!done_seen[0] && extra < 20) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            extra++;
        end
        check_val("t1_done_lat", 64'(extra), 64'd1);
        check_val("t1_count", 64'(kc[0]), 64'd1);
        check_val("t1_drop", 64'(dc[0]), 64'd0);
        drain(20);

        // T2: backpressure, 20 flagged beats into a 16-deep FIFO
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 20; b++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check_val("t2_count", 64'(kc[0]), 64'd16);
        check_val("t2_drop", 64'(dc[0]), 64'd4);
        check_val("t2_count_max3", 64'(kc[2]), 64'd3);
        check_val("t2_drop_max3", 64'(dc[2]), 64'd17);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            check_val("t2_order", 64'(kx[0]), 64'(k));
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check_val("t2_empty", 64'(kpv[0]), 64'd0);

        // T3: full FIFO, flagged beat with a same-cycle pop
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 16; b++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        saved = int'(dc[0]);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check_val("t3_drop", 64'(dc[0]), 64'(saved));
        check_val("t3_count", 64'(kc[0]), 64'd17);

        // T4: pipeline-fill beats discarded on the PIX_DELAY=11 instance
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 20; b++) begin
            cycle(1'b0, 1'b1, b < 12, 1'b1);
            if (b == 11) begin
                check_val("t4_valid", 64'(kpv[1]), 64'd1);
                check_val("t4_xy", 64'({kx[1], ky[1]}), 64'd0);
            end
        end
        check_val("t4_count", 64'(kc[1]), 64'd1);

        // T5: abort with entries queued
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 5; b++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_val("t5_valid", 64'(kpv[0]), 64'd0);
        check_val("t5_count", 64'(kc[0]), 64'd0);
        check_val("t5_drop", 64'(dc[0]), 64'd0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // T6: every pixel flagged; MAX_KP=3 instance caps and drop counter saturates
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < W * H; b++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
        drain(30);
        check_val("t6_count", 64'(kc[2]), 64'd3);
        check_val("t6_drop", 64'(dc[2]), 64'd1023);
        check_val("t6_done", 64'(done_seen[2]), 64'd1);

        // Random frames, including a random abort
        for (int fr = 0; fr < 3; fr++) begin
            int budget;
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
            budget = (fr == 1) ? 300 : 6000;
            for (int k = 0; k < budget && (active[0] || active[1] || active[2]); k++)
                cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 2) != 0));
            if (fr != 1) begin
                drain(40);
                check_val("rnd_done", 64'(done_seen[0] && done_seen[1] && done_seen[2]), 64'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
